// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand adder: operands fold into a carry-save sum/carry pair,
// and one carry-propagate add per packet produces the binary total.
module csa_stream_accumulator #(
    parameter int N     = 4,
    parameter int GUARD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N+GUARD-1:0]   out_sum,
    output logic [GUARD:0]       out_count,
    output logic                 out_ovf
);
    localparam int W  = N + GUARD;
    localparam int CW = GUARD + 1;
    localparam logic [CW-1:0] CNT_OVF = {1'b1, {GUARD{1'b0}}};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_RES = 2'd1,
        ST_OUT = 2'd2
    } state_e;

    function automatic logic [W-1:0] maj3(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_e         state_q, state_d;
    logic [W-1:0]   s_q, s_d, c_q, c_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_sum_q, out_sum_d;
    logic [CW-1:0]  out_count_q, out_count_d;
    logic           out_ovf_q, out_ovf_d;
    logic [W-1:0]   x_s, maj_s;

    // Next-state logic for the carry-save core and the result handshake
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        x_s         = {{GUARD{1'b0}}, in_data};
        maj_s       = maj3(s_q, c_q, x_s);
        case (state_q)
            ST_ACC: begin
                if (in_valid && in_ready_q) begin
                    s_d   = s_q ^ c_q ^ x_s;
                    // Carry out of the MSB is dropped: arithmetic is modulo 2^W
                    c_d   = {maj_s[W-2:0], 1'b0};
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    ovf_d = ovf_q | (cnt_q == CNT_OVF);
                    if (in_last) begin
                        state_d    = ST_RES;
                        in_ready_d = 1'b0;
                    end else begin
                        state_d    = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_RES: begin
                out_sum_d   = s_q + c_q;
                out_count_d = cnt_q;
                out_ovf_d   = ovf_q;
                s_d         = {W{1'b0}};
                c_d         = {W{1'b0}};
                cnt_d       = {CW{1'b0}};
                ovf_d       = 1'b0;
                state_d     = ST_OUT;
                out_valid_d = 1'b1;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d     = ST_ACC;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d     = ST_OUT;
                end
            end
            default: begin
                state_d     = ST_ACC;
                s_d         = {W{1'b0}};
                c_d         = {W{1'b0}};
                cnt_d       = {CW{1'b0}};
                ovf_d       = 1'b0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACC;
            s_q         <= {W{1'b0}};
            c_q         <= {W{1'b0}};
            cnt_q       <= {CW{1'b0}};
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= {W{1'b0}};
            out_count_q <= {CW{1'b0}};
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
